hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and mult/div occupancy.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int MD_LATENCY   = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rt,
    input  logic       id_md_start,
    input  logic       ex_mem_r,
    input  logic [4:0] ex_rt_addr,
    input  logic       ex_branch_taken,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       md_busy,
    output logic [1:0] ctrl_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        FLUSH   = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    localparam logic [3:0] MD_LOAD    = 4'(MD_LATENCY - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       load_use;

    // A load targeting $0 never creates a dependency.
    assign load_use = ex_mem_r && (ex_rt_addr != 5'd0) &&
                      ((ex_rt_addr == id_rs_addr) || (id_uses_rt && (ex_rt_addr == id_rt_addr)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        md_busy      = 1'b0;
        state_next   = state_reg;
        cnt_next     = cnt_reg;

        case (state_reg)
            RUN: begin
                if (ex_branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next = FLUSH;
                        cnt_next   = FLUSH_LOAD;
                    end
                end else if (load_use) begin
                    // Mult/div held in ID here; it retries once the load has moved on.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (id_md_start) begin
                    state_next = MD_WAIT;
                    cnt_next   = MD_LOAD;
                end
            end
            MD_WAIT: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                md_busy      = 1'b1;
                if (cnt_reg == 4'd0) state_next = RUN;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (cnt_reg == 4'd0) state_next = RUN;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            default: begin
                // Unreachable encoding: hold the front end and fall back to RUN.
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                state_next   = RUN;
                cnt_next     = 4'd0;
            end
        endcase

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            md_busy      = 1'b0;
        end
    end

    assign ctrl_state = state_reg;

`ifdef HAZARD_STATS_EN
    logic [1:0] stat_inc;
    assign stat_inc[0] = !pc_write && !rst;
    assign stat_inc[1] = if_id_flush && !rst;

    for (genvar gi = 0; gi < 2; gi++) begin : gen_stat
        logic [15:0] count_reg;
        always_ff @(posedge clk) begin
            if (rst)
                count_reg <= 16'd0;
            else if (stat_inc[gi] && (count_reg != 16'hFFFF))
                count_reg <= count_reg + 16'd1;
        end
        if (gi == 0) begin : gen_stall
            assign stall_cnt = count_reg;
        end else begin : gen_flush
            assign flush_cnt = count_reg;
        end
    end
`endif

endmodule
